// File: rtl/wired_iq_select_if.sv
// wired_iq_select_if: dispatch, entry strobe and FU issue signals of one issue-queue scheduler
interface wired_iq_select_if #(
  parameter int IQ_DEPTH = 8,
  parameter int DISPATCH_CNT = 2
);
  localparam int W = $clog2(IQ_DEPTH);
  logic flush_i;
  logic [DISPATCH_CNT-1:0] disp_valid_i;
  logic disp_ready_o;
  logic [DISPATCH_CNT-1:0][W-1:0] disp_slot_o;
  logic [IQ_DEPTH-1:0] entry_updata_o;
  logic [IQ_DEPTH-1:0] entry_ready_i;
  logic [IQ_DEPTH-1:0] entry_sel_o;
  logic issue_valid_o;
  logic issue_ready_i;
  logic [W-1:0] issue_slot_o;
  logic [W:0] free_cnt_o;
  modport master (
    input flush_i, disp_valid_i, entry_ready_i, issue_ready_i,
    output disp_ready_o, disp_slot_o, entry_updata_o, entry_sel_o, issue_valid_o, issue_slot_o, free_cnt_o
  );
  modport slave (
    output flush_i, disp_valid_i, entry_ready_i, issue_ready_i,
    input disp_ready_o, disp_slot_o, entry_updata_o, entry_sel_o, issue_valid_o, issue_slot_o, free_cnt_o
  );
endinterface

// File: rtl/wired_iq_select.sv
// wired_iq_select: issue-queue slot allocation, age ordering and oldest-ready issue select.
// Optional WIRED_IQ_SELECT_PERF_EN adds issue / FU-stall / queue-full counters.
module wired_iq_select #(
  parameter int IQ_DEPTH = 8,
  parameter int DISPATCH_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  wired_iq_select_if.master bus
`ifdef WIRED_IQ_SELECT_PERF_EN
  ,
  output logic [31:0] perf_issue_o,
  output logic [31:0] perf_fu_stall_o,
  output logic [31:0] perf_full_o
`endif
);
  localparam int W = $clog2(IQ_DEPTH);
  localparam int C = W + 1;
  logic [IQ_DEPTH-1:0] valid, issued_last, updata, sel, cand, keep, prior;
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] older, older_nxt;
  logic [C-1:0] free_cnt, nfire;
  logic [DISPATCH_CNT-1:0] fire;
  logic [DISPATCH_CNT-1:0][W-1:0] slot;
  logic [W-1:0] issue_slot;
  logic disp_ready, issue_valid, accept;
  assign disp_ready = (free_cnt >= C'(DISPATCH_CNT)) && !bus.flush_i;
  assign fire = bus.disp_valid_i & {DISPATCH_CNT{disp_ready}};
  assign cand = valid & bus.entry_ready_i & ~issued_last;
  assign issue_valid = (|cand) && !bus.flush_i;
  assign accept = issue_valid && bus.issue_ready_i;
  assign sel = accept ? IQ_DEPTH'(1) << issue_slot : '0;
  // lane k takes the k-th lowest free slot
  always_comb begin
    int n;
    n = 0;
    slot = '0;
    updata = '0;
    nfire = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      if (!valid[i]) begin
        for (int k = 0; k < DISPATCH_CNT; k++)
          if (n == k) slot[k] = W'(i);
        n++;
      end
    for (int k = 0; k < DISPATCH_CNT; k++)
      if (fire[k]) begin
        updata[slot[k]] = 1'b1;
        nfire = nfire + C'(1);
      end
  end
  // a new entry is younger than every survivor and every lower-lane sibling
  always_comb begin
    older_nxt = older;
    keep = valid & ~sel;
    prior = '0;
    for (int k = 0; k < DISPATCH_CNT; k++)
      if (fire[k]) begin
        for (int x = 0; x < IQ_DEPTH; x++) older_nxt[x][slot[k]] = keep[x] | prior[x];
        older_nxt[slot[k]] = '0;
        prior[slot[k]] = 1'b1;
      end
    for (int x = 0; x < IQ_DEPTH; x++)
      if (sel[x]) begin
        older_nxt[x] = '0;
        for (int y = 0; y < IQ_DEPTH; y++) older_nxt[y][x] = 1'b0;
      end
  end
  always_comb begin
    logic hit, blk;
    hit = 1'b0;
    blk = 1'b0;
    issue_slot = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < IQ_DEPTH; j++) blk = blk | (cand[j] & older[j][i]);
      if (cand[i] && !blk && !hit) begin
        issue_slot = W'(i);
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst || bus.flush_i) begin
      valid <= '0;
      older <= '0;
      free_cnt <= C'(IQ_DEPTH);
      issued_last <= '0;
    end else begin
      valid <= (valid | updata) & ~sel;
      older <= older_nxt;
      free_cnt <= free_cnt - nfire + C'(accept);
      issued_last <= sel;
    end
`ifdef WIRED_IQ_SELECT_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_issue_o <= '0;
      perf_fu_stall_o <= '0;
      perf_full_o <= '0;
    end else begin
      perf_issue_o <= perf_issue_o + 32'(accept);
      perf_fu_stall_o <= perf_fu_stall_o + 32'(issue_valid && !bus.issue_ready_i);
      perf_full_o <= perf_full_o + 32'((|bus.disp_valid_i) && !disp_ready);
    end
`endif
  assign bus.disp_ready_o = disp_ready;
  assign bus.disp_slot_o = slot;
  assign bus.entry_updata_o = updata;
  assign bus.entry_sel_o = sel;
  assign bus.issue_valid_o = issue_valid;
  assign bus.issue_slot_o = issue_slot;
  assign bus.free_cnt_o = free_cnt;
endmodule

// File: tb/tb_wired_iq_select.sv
// tb_wired_iq_select: directed checks of a 4-entry, 2-lane scheduler
module tb_wired_iq_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  wired_iq_select_if #(.IQ_DEPTH(4), .DISPATCH_CNT(2)) bus ();
`ifdef WIRED_IQ_SELECT_PERF_EN
  logic [31:0] perf_issue, perf_fu_stall, perf_full;
`endif
  wired_iq_select #(.IQ_DEPTH(4), .DISPATCH_CNT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
`ifdef WIRED_IQ_SELECT_PERF_EN
    ,
    .perf_issue_o(perf_issue),
    .perf_fu_stall_o(perf_fu_stall),
    .perf_full_o(perf_full)
`endif
  );
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic [1:0] dv, input logic [3:0] rdy, input logic ir);
    bus.flush_i = fl;
    bus.disp_valid_i = dv;
    bus.entry_ready_i = rdy;
    bus.issue_ready_i = ir;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.free_cnt_o !== 3'd4) begin errors++; $display("FAIL reset_free_cnt got %0d want 4", bus.free_cnt_o); end
    vectors++;
    if ({bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o, bus.issue_valid_o} !== 10'b1_0000_0000_0) begin
      errors++; $display("FAIL reset_outputs got %b want 1000000000", {bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o, bus.issue_valid_o});
    end
  endtask

  task automatic test_fill();
    do_reset();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    vectors++;
    if ({bus.disp_slot_o[1], bus.disp_slot_o[0], bus.entry_updata_o} !== 8'b01_00_0011) begin
      errors++; $display("FAIL fill_first got %b want 01000011", {bus.disp_slot_o[1], bus.disp_slot_o[0], bus.entry_updata_o});
    end
    cyc();
    vectors++;
    if (bus.free_cnt_o !== 3'd2) begin errors++; $display("FAIL fill_cnt2 got %0d want 2", bus.free_cnt_o); end
    vectors++;
    if ({bus.disp_slot_o[1], bus.disp_slot_o[0], bus.entry_updata_o} !== 8'b11_10_1100) begin
      errors++; $display("FAIL fill_second got %b want 11101100", {bus.disp_slot_o[1], bus.disp_slot_o[0], bus.entry_updata_o});
    end
    cyc();
    vectors++;
    if ({bus.free_cnt_o, bus.disp_ready_o, bus.entry_updata_o} !== 8'b000_0_0000) begin
      errors++; $display("FAIL fill_full got %b want 00000000", {bus.free_cnt_o, bus.disp_ready_o, bus.entry_updata_o});
    end
  endtask

  task automatic test_age_pick();
    do_reset();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    vectors++;
    if (bus.disp_slot_o[0] !== 2'd2) begin errors++; $display("FAIL age_disp_slot got %0d want 2", bus.disp_slot_o[0]); end
    cyc();
    drive(1'b0, 2'b00, 4'b0110, 1'b1);
    vectors++;
    if ({bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o} !== 7'b1_01_0010) begin
      errors++; $display("FAIL age_first got %b want 1010010", {bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o});
    end
    cyc();
    #1;
    vectors++;
    if ({bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o} !== 7'b1_10_0100) begin
      errors++; $display("FAIL age_second got %b want 1100100", {bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o});
    end
    cyc();
    #1;
    vectors++;
    if ({bus.issue_valid_o, bus.entry_sel_o, bus.free_cnt_o} !== 8'b0_0000_011) begin
      errors++; $display("FAIL age_no_reselect got %b want 00000011", {bus.issue_valid_o, bus.entry_sel_o, bus.free_cnt_o});
    end
  endtask

  task automatic test_reuse();
    logic [1:0] want [3];
    want = '{2'd0, 2'd2, 2'd1};
    do_reset();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 4'b0010, 1'b1);
    cyc();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    vectors++;
    if ({bus.disp_ready_o, bus.disp_slot_o[0], bus.entry_updata_o} !== 7'b1_01_0010) begin
      errors++; $display("FAIL reuse_slot got %b want 1010010", {bus.disp_ready_o, bus.disp_slot_o[0], bus.entry_updata_o});
    end
    cyc();
    drive(1'b0, 2'b00, 4'b0111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.issue_valid_o, bus.issue_slot_o} !== {1'b1, want[i]}) begin
        errors++; $display("FAIL reuse_order_%0d got v=%b slot=%0d want v=1 slot=%0d", i, bus.issue_valid_o, bus.issue_slot_o, want[i]);
      end
      cyc();
      #1;
    end
    vectors++;
    if ({bus.issue_valid_o, bus.free_cnt_o} !== 4'b0_100) begin
      errors++; $display("FAIL reuse_drained got %b want 0100", {bus.issue_valid_o, bus.free_cnt_o});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o, bus.free_cnt_o} !== 10'b1_00_0000_011) begin
        errors++; $display("FAIL stall_%0d got %b want 1000000011", i, {bus.issue_valid_o, bus.issue_slot_o, bus.entry_sel_o, bus.free_cnt_o});
      end
      cyc();
    end
`ifdef WIRED_IQ_SELECT_PERF_EN
    vectors++;
    if (perf_fu_stall !== 32'd3) begin errors++; $display("FAIL perf_fu_stall got %0d want 3", perf_fu_stall); end
`endif
    drive(1'b0, 2'b00, 4'b0001, 1'b1);
    vectors++;
    if (bus.entry_sel_o !== 4'b0001) begin errors++; $display("FAIL stall_accept got %b want 0001", bus.entry_sel_o); end
    cyc();
    vectors++;
    if (bus.free_cnt_o !== 3'd4) begin errors++; $display("FAIL stall_freed got %0d want 4", bus.free_cnt_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b01, 4'b0100, 1'b1);
    vectors++;
    if ({bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o} !== 9'b0_0000_0100) begin
      errors++; $display("FAIL simul_blocked got %b want 000000100", {bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o});
    end
    cyc();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    vectors++;
    if ({bus.free_cnt_o, bus.disp_ready_o, bus.disp_slot_o[0]} !== 6'b001_0_10) begin
      errors++; $display("FAIL simul_next got %b want 001010", {bus.free_cnt_o, bus.disp_ready_o, bus.disp_slot_o[0]});
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b0, 2'b11, 4'b0000, 1'b0);
    cyc();
    drive(1'b0, 2'b01, 4'b0000, 1'b0);
    cyc();
    drive(1'b1, 2'b11, 4'b0001, 1'b1);
    vectors++;
    if ({bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o, bus.issue_valid_o} !== 10'b0_0000_0000_0) begin
      errors++; $display("FAIL flush_cycle got %b want 0000000000", {bus.disp_ready_o, bus.entry_updata_o, bus.entry_sel_o, bus.issue_valid_o});
    end
    cyc();
    drive(1'b0, 2'b00, 4'b0001, 1'b1);
    vectors++;
    if ({bus.free_cnt_o, bus.issue_valid_o} !== 4'b100_0) begin
      errors++; $display("FAIL flush_after got %b want 1000", {bus.free_cnt_o, bus.issue_valid_o});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_age_pick();
    test_reuse();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wired_iq_select.md
Name: wired_iq_select

Overview:
- Scheduler for one issue queue built from `wired_iq_entry` instances; owns slot allocation, age ordering and issue selection.
- Drives each entry's `updata_i` (write) and `sel_i` (issue) strobes; consumes each entry's registered `ready_o`.
- Hands at most one oldest-ready instruction per cycle to the functional unit through a valid/ready handshake.
- Sits between the dispatch stage and the FU port of one execution cluster.

Parameters:
- IQ_DEPTH, 8, number of entries; power of two, 2..16.
- DISPATCH_CNT, 2, dispatch lanes per cycle; 1..IQ_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; kill all entries.
- disp_valid_i  in  DISPATCH_CNT  per-lane dispatch request; lanes packed from lane 0.
- disp_ready_o  out  1  all lanes may dispatch this cycle.
- disp_slot_o  out  DISPATCH_CNT x $clog2(IQ_DEPTH)  slot assigned to each lane.
- entry_updata_o  out  IQ_DEPTH  per-entry write strobe.
- entry_ready_i  in  IQ_DEPTH  per-entry operand-ready, from entry ready_o.
- entry_sel_o  out  IQ_DEPTH  one-hot issue strobe, drives entry sel_i.
- issue_valid_o  out  1  an instruction is offered to the FU.
- issue_ready_i  in  1  FU accepts.
- issue_slot_o  out  $clog2(IQ_DEPTH)  slot being offered.
- free_cnt_o  out  $clog2(IQ_DEPTH)+1  registered free-entry count.

Behaviour:
- State registers:
  - valid[IQ_DEPTH];
  - age matrix older[i][j], where 1 means entry i is older than entry j;
  - free_cnt.
- Reset (rst=1 at a clk edge):
  - valid=0, older=0, free_cnt=IQ_DEPTH.
  - Outputs in the cycle after reset: disp_ready_o=1, entry_updata_o=0, entry_sel_o=0, issue_valid_o=0.
- disp_ready_o = (free_cnt >= DISPATCH_CNT) && !flush_i. All-or-nothing; free_cnt is registered, so slots freed this cycle are not reusable until next cycle.
- Dispatch fires for lane k when disp_valid_i[k] && disp_ready_o.
  - Lane k takes the k-th lowest-index slot with valid=0; disp_slot_o is valid combinationally in that cycle.
  - entry_updata_o has a bit set for every fired lane's slot.
  - Next cycle: valid[slot]=1.
  - Age update for each new slot j: older[x][j]=1 for every x already valid, and for every slot taken by a lower-numbered lane in the same cycle; older[j][*]=0.
- Issue candidate set: cand = valid & entry_ready_i & ~issued_last, where issued_last is the registered entry_sel_o.
  - issued_last covers the one cycle in which an entry's registered ready is stale after issue.
- Oldest candidate: slot i in cand with no j in cand where older[j][i]=1.
  - issue_valid_o = |cand && !flush_i; issue_slot_o = that slot (0 when none).
- Handshake:
  - entry_sel_o[issue_slot_o]=1 only when issue_valid_o && issue_ready_i.
  - Next cycle: valid[slot]=0, its age row and column cleared.
  - An unaccepted offer may change slot next cycle if an older entry becomes ready. Offers are not sticky; the FU latches payload on accept only.
- free_cnt_next = free_cnt - fired lanes + (issue accepted ? 1 : 0).
  - Never exceeds IQ_DEPTH and never underflows; the verification environment asserts both.
- Simultaneous dispatch and issue in one cycle: both take effect. A newly written slot is never a candidate in its write cycle, because valid is still 0.
- Flush:
  - valid=0, older=0, free_cnt=IQ_DEPTH on the next edge.
  - During the flush cycle, entry_sel_o=0 and entry_updata_o=0.
  - Flush wins over dispatch and issue.
- rst mid-operation behaves exactly as flush plus reset of the optional counters.
- Latency:
  - dispatch -> earliest possible issue: 2 cycles (entry registers operands, then entry registers ready).
  - issue accept -> slot reusable: 1 cycle.

Optional Feature:
- WIRED_IQ_SELECT_PERF_EN, when defined, adds three 32-bit wrapping counters, reset to 0 by rst only (not by flush):
  - perf_issue_o: counts accepted issues.
  - perf_fu_stall_o: counts cycles with issue_valid_o && !issue_ready_i.
  - perf_full_o: counts cycles with any disp_valid_i && !disp_ready_o.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Fill: IQ_DEPTH=4, DISPATCH_CNT=2; dispatch 2 lanes for 2 cycles -> disp_slot_o={0,1} then {2,3}; free_cnt_o 4->2->0; disp_ready_o=0 at free_cnt_o=0.
- Age pick: dispatch slots 0,1,2 in order, raise entry_ready_i=4'b0110, issue_ready_i=1 -> issue_slot_o=1, entry_sel_o=4'b0010, then slot 2 next cycle; slot 1 is not reselected.
- Reuse: with slot 1 freed, dispatch 1 lane -> disp_slot_o=1, and an entry_ready_i mask of 4'b0111 then picks slot 0, then 2, then 1 (age preserved over index).
- Backpressure: ready entry present, issue_ready_i=0 for 3 cycles -> issue_valid_o=1, entry_sel_o=0 throughout; valid unchanged; perf_fu_stall_o=3 with WIRED_IQ_SELECT_PERF_EN defined.
- Simultaneous: full queue, issue accepted while disp_valid_i=2'b01 -> dispatch blocked this cycle (free_cnt=0); next cycle disp_slot_o equals the issued slot.
- Flush: queue holding 3 entries, flush_i=1 with disp_valid_i=2'b11 -> entry_updata_o=0, entry_sel_o=0; next cycle free_cnt_o=4, issue_valid_o=0.
